// File: rtl/top_cell.sv
// top_cell: digit-serial GF(2^M) multiplier, p = a*b mod (x^M + g), M = WEIGHT*N.
// Latency: with L the edge capturing the last a/g digit, po carries p digit N-1
//   after edge L+N and digit 0 after edge L+2N-1. No backpressure: the host
//   sequences ctr and must present digits on schedule; new loads only from IDLE.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (forces IDLE, po = 0 immediately)
//   ctr  - load strobe, high while ai/gi carry digits (MSB digit first)
//   ai   - a digit, ai[WEIGHT] is the MSB
//   gi   - g digit (low M bits of the field polynomial)
//   bi   - b digit, leads ai/gi by one cycle
//   po   - product digit, po[1] is the MSB; zero outside the OUT phase
//   done - (only with GF_DONE_PORT_EN defined) high during the N OUT cycles
// Optional feature macro: GF_DONE_PORT_EN adds the done output.

module top_cell #(
  parameter int WEIGHT = 32,
  parameter int N      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctr,
  input  logic [WEIGHT:1]   ai,
  input  logic [WEIGHT:1]   gi,
  input  logic [WEIGHT:1]   bi,
  output logic [1:WEIGHT]   po
`ifdef GF_DONE_PORT_EN
  ,
  output logic              done
`endif
);

  localparam int M  = WEIGHT * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t          state_q;
  logic [M-1:0]    a_q;
  logic [M-1:0]    g_q;
  logic [M-1:0]    b_q;
  logic [M-1:0]    p_q;
  // Load digit count in LOAD, b digit index k in COMPUTE, output digit count in OUT.
  logic [CW-1:0]   cnt_q;

  logic [WEIGHT-1:0] b_dig;
  logic [M-1:0]      p_d;

  // One b digit per edge: WEIGHT MSB-first multiply-accumulate steps,
  // each step P = P*x mod f xor (bit ? A : 0).
  function automatic logic [M-1:0] mac_digit(
    input logic [M-1:0]      p,
    input logic [M-1:0]      a,
    input logic [M-1:0]      g,
    input logic [WEIGHT-1:0] bd
  );
    logic [M-1:0] acc;
    acc = p;
    for (int j = WEIGHT - 1; j >= 0; j--) begin
      acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? g : '0) ^ (bd[j] ? a : '0);
    end
    return acc;
  endfunction

  always_comb begin
    b_dig = b_q[int'(cnt_q) * WEIGHT +: WEIGHT];
    p_d   = mac_digit(p_q, a_q, g_q, b_dig);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // b runs one digit ahead, so it shifts every idle cycle.
          b_q <= {b_q[M-WEIGHT-1:0], bi};
          if (ctr) begin
            a_q     <= {a_q[M-WEIGHT-1:0], ai};
            g_q     <= {g_q[M-WEIGHT-1:0], gi};
            cnt_q   <= CW'(1);
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (!ctr) begin
            // Aborted load: partial a/g are discarded, b keeps its idle shifting.
            b_q     <= {b_q[M-WEIGHT-1:0], bi};
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == LAST) begin
            // Last a/g digit; b already holds all N digits so it holds here.
            a_q     <= {a_q[M-WEIGHT-1:0], ai};
            g_q     <= {g_q[M-WEIGHT-1:0], gi};
            p_q     <= '0;
            cnt_q   <= LAST;
            state_q <= COMPUTE;
          end else begin
            a_q   <= {a_q[M-WEIGHT-1:0], ai};
            g_q   <= {g_q[M-WEIGHT-1:0], gi};
            b_q   <= {b_q[M-WEIGHT-1:0], bi};
            cnt_q <= cnt_q + CW'(1);
          end
        end
        COMPUTE: begin
          p_q <= p_d;
          if (cnt_q == '0) begin
            state_q <= OUT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        OUT: begin
          p_q <= {p_q[M-WEIGHT-1:0], {WEIGHT{1'b0}}};
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Combinational from state so reset clears po without a clock edge.
  assign po = (state_q == OUT) ? p_q[M-1 -: WEIGHT] : '0;

`ifdef GF_DONE_PORT_EN
  assign done = (state_q == OUT);
`endif

endmodule

// File: tb/tb_top_cell.sv
// tb_top_cell: scoreboard bench for the digit-serial GF(2^192) multiplier.
// Expected product digits are queued when a load is driven and popped as
// the DUT emits them; a shift-and-reduce reference model provides products.

module tb_top_cell;

  localparam int W = 32;
  localparam int N = 6;
  localparam int M = W * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         ctr;
  logic [W:1]   ai;
  logic [W:1]   gi;
  logic [W:1]   bi;
  logic [1:W]   po;
`ifdef GF_DONE_PORT_EN
  logic         done;
`endif

  top_cell #(.WEIGHT(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .ctr (ctr),
    .ai  (ai),
    .gi  (gi),
    .bi  (bi),
    .po  (po)
`ifdef GF_DONE_PORT_EN
    ,
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] sb_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] rnd192();
    logic [M-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r = {r[M-W-1:0], W'($urandom)};
    return r;
  endfunction

  // Full carry-less product, then clear bits from the top using x^M = g.
  function automatic logic [M-1:0] gf_ref(input logic [M-1:0] a, input logic [M-1:0] b,
                                          input logic [M-1:0] g);
    logic [2*M-1:0] prod;
    prod = '0;
    for (int i = 0; i < M; i++)
      if (b[i]) prod = prod ^ ({{M{1'b0}}, a} << i);
    for (int i = 2*M-1; i >= M; i--) begin
      if (prod[i]) begin
        prod    = prod ^ ({{M{1'b0}}, g} << (i - M));
        prod[i] = 1'b0;
      end
    end
    return prod[M-1:0];
  endfunction

  // Drive one load and watch 2N+1 edges after it. rst_at >= 0 pulses reset
  // at that observation point and abandons the operation.
  task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [M-1:0] g,
                        input logic [M-1:0] exp, input int rst_at);
    logic [W-1:0] e_dig;
    for (int d = N - 1; d >= 0; d--) sb_q.push_back(exp[d*W +: W]);
    @(negedge clk);
    ctr = 1'b0;
    bi  = b[(N-1)*W +: W];
    ai  = W'($urandom);
    gi  = W'($urandom);
    for (int d = N - 1; d >= 0; d--) begin
      @(negedge clk);
      ctr = 1'b1;
      ai  = a[d*W +: W];
      gi  = g[d*W +: W];
      if (d > 0) bi = b[(d-1)*W +: W];
      else       bi = W'($urandom);
    end
    // Observation e sees the state after edge L+e.
    for (int e = 0; e <= 2*N; e++) begin
      @(negedge clk);
      ai = W'($urandom);
      gi = W'($urandom);
      bi = W'($urandom);
      if (e == 0 || e == 2*N) ctr = 1'b0;
      else                    ctr = 1'($urandom_range(0, 1));
      if (e == rst_at) begin
        ctr = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_po_immediate", po, '0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_release_po", po, '0);
        sb_q.delete();
        return;
      end
`ifdef GF_DONE_PORT_EN
      check("done", W'(done), W'((e >= N && e < 2*N) ? 1 : 0));
`endif
      if (e < N) begin
        check("busy_po_zero", po, '0);
      end else if (e < 2*N) begin
        if (sb_q.size() == 0) begin
          check("scoreboard_empty", W'(1), W'(0));
        end else begin
          e_dig = sb_q.pop_front();
          check("po_digit", po, e_dig);
        end
      end else begin
        check("idle_po_zero", po, '0);
      end
    end
  endtask

  task automatic run_abort();
    @(negedge clk);
    ctr = 1'b0;
    bi  = W'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ctr = 1'b1;
      ai  = W'($urandom);
      gi  = W'($urandom);
      bi  = W'($urandom);
    end
    for (int i = 0; i < 2*N + 2; i++) begin
      @(negedge clk);
      ctr = 1'b0;
      bi  = W'($urandom);
      check("abort_po_zero", po, '0);
    end
  endtask

  logic [M-1:0] a_v, b_v, g_v, g_id;

  initial begin
    rst = 1'b1;
    ctr = 1'b0;
    ai  = '0;
    gi  = '0;
    bi  = '0;

    // Reset held with noisy inputs.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ctr = 1'($urandom_range(0, 1));
      ai  = W'($urandom);
      gi  = W'($urandom);
      bi  = W'($urandom);
      check("reset_po", po, '0);
    end
    @(negedge clk);
    rst = 1'b0;
    ctr = 1'b0;
    check("post_reset_po", po, '0);
    @(negedge clk);
    check("post_reset_idle", po, '0);

    g_id = '0;
    g_id[2*W +: W] = 32'h19200000;

    // Identity: a = 1 so the product is b.
    a_v = '0;
    a_v[0] = 1'b1;
    b_v = {32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 32'h4B5A6978, 32'hDEADBEEF, 32'h0000208D};
    run_op(a_v, b_v, g_id, b_v, -1);

    // Reduction: x^191 * x = x^192 = g.
    a_v = '0;
    a_v[M-1] = 1'b1;
    b_v = '0;
    b_v[1] = 1'b1;
    run_op(a_v, b_v, g_id, g_id, -1);

    // Zero operand.
    run_op('0, rnd192(), rnd192(), '0, -1);

    // Random vectors, loaded back to back.
    for (int i = 0; i < 3; i++) begin
      a_v = rnd192();
      b_v = rnd192();
      g_v = rnd192();
      run_op(a_v, b_v, g_v, gf_ref(a_v, b_v, g_v), -1);
    end

    // Aborted load, then a full load must still work.
    run_abort();
    a_v = rnd192();
    b_v = rnd192();
    g_v = rnd192();
    run_op(a_v, b_v, g_v, gf_ref(a_v, b_v, g_v), -1);

    // Reset mid-COMPUTE, then mid-OUT, each followed by a good product.
    run_op(rnd192(), rnd192(), rnd192(), '0, 3);
    a_v = rnd192();
    b_v = rnd192();
    g_v = rnd192();
    run_op(a_v, b_v, g_v, gf_ref(a_v, b_v, g_v), -1);
    a_v = rnd192();
    b_v = rnd192();
    g_v = rnd192();
    run_op(a_v, b_v, g_v, gf_ref(a_v, b_v, g_v), N + 2);
    a_v = rnd192();
    b_v = rnd192();
    g_v = rnd192();
    run_op(a_v, b_v, g_v, gf_ref(a_v, b_v, g_v), -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
